// File: rtl/vpu_pkg.sv
// Shared types and the opcode table for the VPU queued decoder.
// Contents:
//   opcode_e    - opcode encodings (0 is never legal)
//   unit_t      - execution unit selector
//   op_info_t   - per-opcode decode record {src_cnt, delay, unit, func, sub_delay}
//   OP_TABLE    - decode records indexed by opcode, entry 0 is always illegal
//   op_lookup() - table lookup that returns an all-zero record for unknown opcodes
package vpu_pkg;

  localparam int INSTR_NUM  = 11;
  localparam int OP_IDX_W   = $clog2(INSTR_NUM + 1);

  typedef enum logic [5:0] {
    OP_NONE   = 6'd0,
    OP_UIADD3 = 6'd1,
    OP_IADD   = 6'd2,
    OP_ISUB   = 6'd3,
    OP_IMUL   = 6'd4,
    OP_FADD   = 6'd5,
    OP_FDIV   = 6'd6,
    OP_FMAX   = 6'd7,
    OP_FSUM   = 6'd8,
    OP_FAVG   = 6'd9,
    OP_FEXP   = 6'd10,
    OP_VMAD4  = 6'd11
  } opcode_e;

  typedef enum logic [1:0] {
    UNIT_UI  = 2'd0,
    UNIT_SI  = 2'd1,
    UNIT_FP  = 2'd2,
    UNIT_RED = 2'd3
  } unit_t;

  // One-hot function select
  localparam logic [7:0] FUNC_NONE = 8'h00;
  localparam logic [7:0] FUNC_ADD  = 8'h01;
  localparam logic [7:0] FUNC_SUB  = 8'h02;
  localparam logic [7:0] FUNC_MUL  = 8'h04;
  localparam logic [7:0] FUNC_DIV  = 8'h08;
  localparam logic [7:0] FUNC_MAX  = 8'h10;
  localparam logic [7:0] FUNC_AVG  = 8'h20;
  localparam logic [7:0] FUNC_SUM  = 8'h40;
  localparam logic [7:0] FUNC_EXP  = 8'h80;

  typedef struct packed {
    logic [2:0] src_cnt;
    logic [3:0] delay;
    unit_t      unit;
    logic [7:0] func;
    logic [1:0] sub_delay;
  } op_info_t;

  // src_cnt of 0 marks an entry as illegal. VMAD4 needs four read ports and is
  // only legal in a build with SRC_CNT >= 4.
  localparam op_info_t OP_TABLE [INSTR_NUM+1] = '{
    '{3'd0, 4'd0, UNIT_UI,  FUNC_NONE, 2'd0},  // OP_NONE
    '{3'd3, 4'd2, UNIT_UI,  FUNC_ADD,  2'd0},  // OP_UIADD3
    '{3'd2, 4'd2, UNIT_SI,  FUNC_ADD,  2'd0},  // OP_IADD
    '{3'd2, 4'd2, UNIT_SI,  FUNC_SUB,  2'd0},  // OP_ISUB
    '{3'd2, 4'd4, UNIT_SI,  FUNC_MUL,  2'd0},  // OP_IMUL
    '{3'd2, 4'd5, UNIT_FP,  FUNC_ADD,  2'd0},  // OP_FADD
    '{3'd2, 4'd9, UNIT_FP,  FUNC_DIV,  2'd0},  // OP_FDIV
    '{3'd2, 4'd3, UNIT_FP,  FUNC_MAX,  2'd0},  // OP_FMAX
    '{3'd1, 4'd6, UNIT_RED, FUNC_SUM,  2'd2},  // OP_FSUM
    '{3'd1, 4'd7, UNIT_RED, FUNC_AVG,  2'd3},  // OP_FAVG
    '{3'd1, 4'd8, UNIT_FP,  FUNC_EXP,  2'd0},  // OP_FEXP
    '{3'd4, 4'd6, UNIT_UI,  FUNC_MUL,  2'd0}   // OP_VMAD4
  };

  // Compare-based lookup so opcodes wider than the table never index out of range.
  function automatic op_info_t op_lookup(input int unsigned op);
    op_info_t info;
    info = '0;
    for (int unsigned i = 1; i <= INSTR_NUM; i++) begin
      if (op == i) info = OP_TABLE[i[OP_IDX_W-1:0]];
    end
    return info;
  endfunction

endpackage

// File: rtl/vpu_sync_fifo.sv
// Synchronous FIFO with asynchronous reset and synchronous flush.
// Ports:
//   clk, rst_n   - clock, async active-low reset
//   flush        - empties the FIFO on the next edge, overrides push/pop
//   push, wdata  - write request; ignored when full (even with a same-cycle pop)
//   pop, rdata   - read request; rdata always shows the head entry
//   full, empty  - occupancy flags
//   level        - number of stored entries
module vpu_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset: level gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/vpu_queued_decoder.sv
// VPU instruction decoder: queues host instructions, decodes the FIFO head over
// DECODE_CYCLE cycles via the package opcode table, and holds the decoded
// request on a valid/ready handshake until the controller accepts it.
// Ports:
//   clk, rst_n, flush_i                   - clock, async reset, sync flush
//   in_valid/in_ready, in_opcode/src/dst  - host instruction push
//   out_valid/out_ready                   - decoded request handshake
//   out_opcode, out_rvalid, out_raddr,
//   out_waddr, out_delay, out_unit,
//   out_func, out_sub_delay               - decoded request fields
//   err_illegal                           - one-cycle pulse per dropped illegal opcode
//   fifo_level                            - instruction FIFO occupancy
//
// state    | meaning
// S_IDLE   | decode register empty, waiting for a queued instruction
// S_DECODE | counting down decode cycles for the instruction in the decode register
// S_HOLD   | decoded request presented with out_valid, waiting for out_ready
module vpu_queued_decoder
  import vpu_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int SRC_CNT      = 3,
  parameter int ADDR_W       = 8,
  parameter int OPCODE_W     = 6,
  parameter int DELAY_W      = 4,
  parameter int DECODE_CYCLE = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [OPCODE_W-1:0]          in_opcode,
  input  logic [SRC_CNT*ADDR_W-1:0]    in_src,
  input  logic [ADDR_W-1:0]            in_dst,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OPCODE_W-1:0]          out_opcode,
  output logic [SRC_CNT-1:0]           out_rvalid,
  output logic [SRC_CNT*ADDR_W-1:0]    out_raddr,
  output logic [ADDR_W-1:0]            out_waddr,
  output logic [DELAY_W-1:0]           out_delay,
  output logic [1:0]                   out_unit,
  output logic [7:0]                   out_func,
  output logic [1:0]                   out_sub_delay,
  output logic                         err_illegal,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

  localparam int FIFO_W = OPCODE_W + SRC_CNT*ADDR_W + ADDR_W;
  localparam int CNT_W  = (DECODE_CYCLE > 1) ? $clog2(DECODE_CYCLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t                    state, state_nx;
  logic [CNT_W-1:0]          cnt, cnt_nx;
  logic                      load;
  logic                      ready_q;

  logic [OPCODE_W-1:0]       dec_opcode;
  logic [SRC_CNT*ADDR_W-1:0] dec_src;
  logic [ADDR_W-1:0]         dec_dst;
  op_info_t                  info;
  logic                      dec_legal;

  logic                      fifo_push;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [FIFO_W-1:0]         fifo_rdata;

  // in_ready stays low until the first edge after reset release.
  assign in_ready  = ready_q && !fifo_full;
  assign fifo_push = in_valid && in_ready;

  vpu_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush_i),
    .push  (fifo_push),
    .wdata ({in_opcode, in_src, in_dst}),
    .pop   (load),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign info      = op_lookup(32'(dec_opcode));
  assign dec_legal = (info.src_cnt != 3'd0) && (int'(info.src_cnt) <= SRC_CNT);

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    load        = 1'b0;
    err_illegal = 1'b0;
    if (flush_i) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            load     = 1'b1;
            cnt_nx   = CNT_W'(DECODE_CYCLE - 1);
            state_nx = S_DECODE;
          end
        end
        S_DECODE: begin
          if (cnt != '0) begin
            cnt_nx = cnt - 1'b1;
          end else if (dec_legal) begin
            state_nx = S_HOLD;
          end else begin
            err_illegal = 1'b1;
            if (!fifo_empty) begin
              load     = 1'b1;
              cnt_nx   = CNT_W'(DECODE_CYCLE - 1);
              state_nx = S_DECODE;
            end else begin
              state_nx = S_IDLE;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            if (!fifo_empty) begin
              load     = 1'b1;
              cnt_nx   = CNT_W'(DECODE_CYCLE - 1);
              state_nx = S_DECODE;
            end else begin
              state_nx = S_IDLE;
            end
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ready_q    <= 1'b0;
      dec_opcode <= '0;
      dec_src    <= '0;
      dec_dst    <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      ready_q <= 1'b1;
      if (load) {dec_opcode, dec_src, dec_dst} <= fifo_rdata;
    end
  end

  // All request fields come straight from the decode register, so they cannot
  // change while in S_HOLD.
  assign out_valid     = (state == S_HOLD);
  assign out_opcode    = dec_opcode;
  assign out_raddr     = dec_src;
  assign out_waddr     = dec_dst;
  assign out_delay     = DELAY_W'(info.delay);
  assign out_unit      = info.unit;
  assign out_func      = info.func;
  assign out_sub_delay = info.sub_delay;

  always_comb begin
    out_rvalid = '0;
    for (int k = 0; k < SRC_CNT; k++) begin
      out_rvalid[k] = (k < int'(info.src_cnt));
    end
  end

endmodule

// File: doc/vpu_queued_decoder.md
# vpu_queued_decoder

Parametrised next-generation VPU instruction decoder. Buffers host instructions in an internal FIFO, decodes the head over a configurable number of cycles using a package-level opcode table, and presents a fully decoded request to the VPU controller on a valid/ready handshake held stable until accepted. Sits between the host request interface and the operand-read/execute controller. Adds illegal-opcode detection, flush, and variable source-operand count beyond three.

## Interface
- `DEPTH`, 4: instruction FIFO entries, power of two, ≥2
- `SRC_CNT`, 3: source operands / SRAM read ports
- `ADDR_W`, 8: SRAM address width
- `OPCODE_W`, 6: opcode width
- `DELAY_W`, 4: execute-delay field width
- `DECODE_CYCLE`, 2: decode cycles per instruction, ≥1

Ports:
- `clk` in 1: single clock
- `rst_n` in 1: asynchronous, active-low reset
- `flush_i` in 1: synchronous flush
- `in_valid` in 1: host instruction valid
- `in_ready` out 1: FIFO not full
- `in_opcode` in OPCODE_W: opcode
- `in_src` in SRC_CNT*ADDR_W: source addresses, src k at bits [k*ADDR_W +: ADDR_W]
- `in_dst` in ADDR_W: destination address
- `out_valid` out 1: decoded request valid
- `out_ready` in 1: controller accepts
- `out_opcode` out OPCODE_W: opcode passthrough
- `out_rvalid` out SRC_CNT: read-port enables, low bits set per source count
- `out_raddr` out SRC_CNT*ADDR_W: source addresses
- `out_waddr` out ADDR_W: destination
- `out_delay` out DELAY_W: execute latency from table
- `out_unit` out 2: `UNIT_UI`/`UNIT_SI`/`UNIT_FP`/`UNIT_RED`
- `out_func` out 8: one-hot function (add, sub, mul, div, max, avg, sum, exp)
- `out_sub_delay` out 2: reduction sub-delay, 0 for non-RED
- `err_illegal` out 1: one-cycle pulse, illegal opcode dropped
- `fifo_level` out $clog2(DEPTH+1): occupancy

## Operation
- Push when `in_valid && in_ready`; `in_ready = !full`. A push is refused when full, even on a same-cycle pop.
- FSM, head of FIFO:
  - IDLE: FIFO non-empty → pop head into decode register, counter=DECODE_CYCLE-1, go DECODE.
  - DECODE: decrement; at counter==0, legal → HOLD; illegal → pulse `err_illegal`, then pop next if non-empty (DECODE) else IDLE.
  - HOLD: `out_valid`=1, all outputs stable. On `out_ready`: FIFO non-empty → pop and go DECODE on the same edge; else IDLE.
- Illegal: opcode 0 or > `INSTR_NUM`. Produces no `out_valid`.
- Table lookup: src count 1 → `out_rvalid`=...001; 2 → ...011; 3 → ...111. Counts above SRC_CNT are illegal.
- `flush_i`: empties the FIFO and returns the FSM to IDLE on the next edge; `out_valid` low in the following cycle. A same-cycle push is discarded. `flush_i` has priority over all other events.
- Async reset: all outputs 0, `fifo_level`=0, FSM IDLE. `in_ready` goes to 1 after the first clock following reset deassertion.

## Timing
- Latency: push at edge E → `out_valid` high after edge E+1+DECODE_CYCLE (FIFO empty, FSM IDLE).
- Throughput: one instruction per DECODE_CYCLE+1 cycles when `out_ready` is held high.
- `out_valid` never drops without `out_ready`, except on flush or reset.
- `fifo_level` updates on the edge after push/pop; a simultaneous push and pop leaves it unchanged.

## Structure
- Package `vpu_pkg` additions:
  - opcode enum
  - `unit_t`
  - `op_info_t` {src_cnt, delay, unit, func, sub_delay}
  - `const op_info_t OP_TABLE[INSTR_NUM+1]`
  - `INSTR_NUM`
- Sub-module `vpu_sync_fifo` (DEPTH, WIDTH), with async reset, a sync flush, and full/empty/level outputs.

## Test plan
- Reset: with `rst_n`=0, all outputs read 0; after release, `in_ready`=1 and `fifo_level`=0.
- Single UIADD3, DECODE_CYCLE=2: push at edge 0 → `out_valid` after edge 3, `out_rvalid`=3'b111, `out_unit`=UNIT_UI, add bit set.
- Back-pressure: push 5 FSUM (DEPTH=4), `out_ready`=0 → `in_ready` low at level 4. Then `out_ready`=1 → five outputs, each 3 cycles apart, `out_sub_delay`=2, `out_rvalid`=001.
- Illegal opcode 0 between two IADD → exactly one `err_illegal` pulse, two `out_valid` handshakes, order preserved.
- Flush while HOLD with 2 queued → `out_valid` low next cycle, `fifo_level`=0, no further outputs.
- Async reset asserted mid-DECODE → outputs cleared immediately, without waiting for `clk`.
